data_memory_loader: RTL and testbench

//  Write-side counterpart of the SAD data memory read port. Accepts a raster pixel stream
//  (valid/ready) and writes it into data memory through one write port:
//  the 64x64 search frame first, then the 4x4 reference window.

---
 rtl/data_memory_loader.sv | 116 +++++++++++
 tb/tb_data_memory_loader.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/data_memory_loader.sv
// Streams a 64x64 search frame, then a 4x4 reference window, into data memory via one write port.
// Optional `define DATA_MEMORY_LOADER_CHECKSUM_EN adds a 16-bit running sum of accepted pixels.
module data_memory_loader #(
  parameter int PIX_W       = 9,
  parameter int ADDR_W      = 13,
  parameter int FRAME_W     = 64,
  parameter int FRAME_H     = 64,
  parameter int WIN_PIX     = 16,
  parameter int FRAME_BASE  = 4,
  parameter int WINDOW_BASE = 4100
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [PIX_W-1:0]  in_data,
  output logic              in_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [PIX_W-1:0]  mem_wr_data,
  output logic              busy,
  output logic              done
`ifdef DATA_MEMORY_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  // state       | meaning
  // S_IDLE      | waiting for start, stream not accepted
  // S_LOAD_FRAME| writing frame pixels at FRAME_BASE+cnt
  // S_LOAD_WIN  | writing window pixels at WINDOW_BASE+cnt
  // S_DONE      | one cycle before returning to idle; done follows a cycle later
  typedef enum logic [1:0] {S_IDLE, S_LOAD_FRAME, S_LOAD_WIN, S_DONE} state_t;

  localparam logic [11:0]       FRAME_LAST = 12'(FRAME_W * FRAME_H - 1);
  localparam logic [11:0]       WIN_LAST   = 12'(WIN_PIX - 1);
  localparam logic [ADDR_W-1:0] FB         = ADDR_W'(FRAME_BASE);
  localparam logic [ADDR_W-1:0] WB         = ADDR_W'(WINDOW_BASE);

  state_t            state, state_nxt;
  logic [11:0]       cnt, cnt_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic              accept;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    in_ready    = 1'b0;
    busy        = 1'b0;
    wr_addr_nxt = FB + ADDR_W'(cnt);
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LOAD_FRAME;
          cnt_nxt   = '0;
        end
      end
      S_LOAD_FRAME: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (cnt == FRAME_LAST) begin
            state_nxt = S_LOAD_WIN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 12'd1;
          end
        end
      end
      S_LOAD_WIN: begin
        in_ready    = 1'b1;
        busy        = 1'b1;
        wr_addr_nxt = WB + ADDR_W'(cnt);
        if (in_valid) begin
          cnt_nxt = cnt + 12'd1;
          if (cnt == WIN_LAST) state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      done        <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_wr_en <= accept;
      done      <= (state == S_DONE);
      if (accept) begin
        mem_wr_addr <= wr_addr_nxt;
        mem_wr_data <= in_data;
      end
    end
  end

`ifdef DATA_MEMORY_LOADER_CHECKSUM_EN
  // Holds after the last beat because nothing is accepted again until the next start.
  always_ff @(posedge Clk) begin
    if (Reset)                         checksum <= '0;
    else if (state == S_IDLE && start) checksum <= '0;
    else if (accept)                   checksum <= checksum + 16'(in_data);
  end
`endif

endmodule

// File: tb/tb_data_memory_loader.sv
// Scoreboard bench for data_memory_loader: driver queues expected writes, monitor pops on mem_wr_en.
module tb_data_memory_loader;
  logic        Clk = 1'b0;
  logic        Reset, start, in_valid;
  logic [8:0]  in_data;
  logic        in_ready, mem_wr_en, busy, done;
  logic [12:0] mem_wr_addr;
  logic [8:0]  mem_wr_data;
`ifdef DATA_MEMORY_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  data_memory_loader dut (
    .Clk(Clk), .Reset(Reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .busy(busy), .done(done)
`ifdef DATA_MEMORY_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct packed {logic [12:0] a; logic [8:0] d;} wr_t;
  wr_t         q[$];
  wr_t         e;
  int          total = 0, bad = 0;
  int          cyc = 0, last_wr_cyc = -10, done_cnt = 0;
  logic [15:0] exp_csum = '0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: every write must match the oldest queued expectation; done must trail the last write by one cycle.
  always @(negedge Clk) begin
    if (mem_wr_en === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%0d data=%0h (none queued)", mem_wr_addr, mem_wr_data);
      end else begin
        e = q.pop_front();
        if (mem_wr_addr !== e.a || mem_wr_data !== e.d) begin
          bad++;
          $display("FAIL write got addr=%0d data=%0h want addr=%0d data=%0h",
                   mem_wr_addr, mem_wr_data, e.a, e.d);
        end
      end
      last_wr_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      total++;
      if (cyc != last_wr_cyc + 1) begin
        bad++;
        $display("FAIL done_latency got cycle=%0d want cycle=%0d", cyc, last_wr_cyc + 1);
      end
`ifdef DATA_MEMORY_LOADER_CHECKSUM_EN
      total++;
      if (checksum !== exp_csum) begin
        bad++;
        $display("FAIL checksum_at_done got=%0h want=%0h", checksum, exp_csum);
      end
`endif
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge Clk); start = 1'b1;
    @(negedge Clk); start = 1'b0;
  endtask

  // gap: idle cycle after each beat; restart_at: beat carrying a stray start; abort_at: beat replaced by Reset
  // dmode 0: frame data=addr[8:0], window 0x1FF; 1: all ones-valued (1); 2: all 0x1FF
  task automatic run_load(input int gap, input int restart_at, input int abort_at, input int dmode);
    int          d0;
    logic [12:0] a;
    logic [8:0]  d;
    d0 = done_cnt;
    pulse_start();
    exp_csum = '0;
    for (int i = 0; i < 4112; i++) begin
      a = (i < 4096) ? 13'(4 + i) : 13'(4100 + i - 4096);
      if (dmode == 0)      d = (i < 4096) ? a[8:0] : 9'h1FF;
      else if (dmode == 1) d = 9'd1;
      else                 d = 9'h1FF;
      @(negedge Clk);
      if (i == 0) begin
        chk("ready_in_load", {31'd0, in_ready}, 32'd1);
        chk("busy_in_load", {31'd0, busy}, 32'd1);
      end
      if (i == abort_at) begin
        in_valid = 1'b0;
        Reset    = 1'b1;
        @(negedge Clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("abort_ready", {31'd0, in_ready}, 32'd0);
        chk("abort_no_done", done_cnt - d0, 32'd0);
        Reset = 1'b0;
        return;
      end
      in_valid = 1'b1;
      in_data  = d;
      start    = (i == restart_at);
      q.push_back({a, d});
      exp_csum = exp_csum + 16'(d);
      if (gap != 0) begin
        @(negedge Clk);
        in_valid = 1'b0;
        start    = 1'b0;
      end
    end
    @(negedge Clk);
    in_valid = 1'b0;
    start    = 1'b0;
    repeat (4) @(negedge Clk);
    chk("done_once", done_cnt - d0, 32'd1);
    chk("queue_drained", q.size(), 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge Clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rst_addr", {19'd0, mem_wr_addr}, 32'd0);
    chk("rst_data", {23'd0, mem_wr_data}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    Reset = 1'b0;

    run_load(0, -1, -1, 0);

    in_valid = 1'b1; in_data = 9'h0AA;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      chk("idle_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;

    run_load(1, -1, -1, 0);
    run_load(0, 100, -1, 0);
    run_load(0, -1, 2000, 0);
    run_load(0, -1, -1, 0);

`ifdef DATA_MEMORY_LOADER_CHECKSUM_EN
    run_load(0, -1, -1, 1);
    chk("checksum_ones", {16'd0, checksum}, 32'h1010);
    run_load(0, -1, -1, 2);
    chk("checksum_1ff", {16'd0, checksum}, 32'h0FF0);
`endif

    chk("queue_empty_end", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
